// File: rtl/sc_reg_write_arbiter_pkg.sv
// Shared types, default widths and address-decode helpers for the register-bank write arbiter.
package sc_reg_write_arbiter_pkg;

    localparam int unsigned DEF_DATAWIDTH = 32;
    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_NUM_REGS  = 8;
    localparam int unsigned DEF_ADDRWIDTH = 3;
    localparam int unsigned DEF_MAX_HOLD  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    // True when the address names a register that physically exists in the bank.
    function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned num_regs);
        return (32'(addr) < num_regs);
    endfunction

    // One bit of the one-hot write-enable decode: register idx is selected by addr.
    function automatic logic reg_select(input logic [7:0] addr, input int unsigned idx,
                                        input int unsigned num_regs);
        return (32'(addr) == idx) && (idx < num_regs);
    endfunction

endpackage

// File: rtl/sc_rr_picker.sv
// Combinational round-robin picker: first eligible index at or above the pointer, wrapping.
module sc_rr_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_valid_o
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_valid_o = 1'b0;
        cand        = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IW'((32'(ptr_i) + off) % N);
            if (!any_valid_o && eligible_i[cand]) begin
                any_valid_o       = 1'b1;
                grant_idx_o       = cand;
                grant_oh_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_reg_write_arbiter.sv
// Round-robin write arbiter with bounded burst lock, driving one shared register bank.
module sc_reg_write_arbiter
    import sc_reg_write_arbiter_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS = DEF_DATAWIDTH,
    parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
    parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
    parameter int unsigned ADDRWIDTH     = DEF_ADDRWIDTH,
    parameter int unsigned MAX_HOLD      = DEF_MAX_HOLD
) (
    input  logic                           SC_RegWRARB_CLOCK_50,
    input  logic                           SC_RegWRARB_Reset_InLow,
    input  logic [NUM_REQ-1:0]             SC_RegWRARB_Req_In,
    input  logic [NUM_REQ-1:0]             SC_RegWRARB_Lock_In,
    input  logic [NUM_REQ*ADDRWIDTH-1:0]   SC_RegWRARB_Addr_In,
    input  logic [NUM_REQ*DATAWIDTH_BUS-1:0] SC_RegWRARB_Data_In,
    output logic [NUM_REQ-1:0]             SC_RegWRARB_Ack_Out,
    output logic [NUM_REGS-1:0]            SC_RegWRARB_Write_Out,
    output logic [DATAWIDTH_BUS-1:0]       SC_RegWRARB_DataBUS_Out,
    output logic                           SC_RegWRARB_Error_Out,
    output logic                           SC_RegWRARB_Busy_Out
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_e               state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [NUM_REQ-1:0]       ack_q, ack_d;
    logic [NUM_REGS-1:0]      write_q, write_d;
    logic [DATAWIDTH_BUS-1:0] data_q, data_d;
    logic                     error_q, error_d;
    logic                     busy_q, busy_d;

    logic [NUM_REQ-1:0]       eligible;
    logic [NUM_REQ-1:0]       pick_oh;
    logic [PTR_W-1:0]         pick_idx;
    logic                     pick_any;
    logic                     owner_hold;
    logic                     grant;
    logic [PTR_W-1:0]         gidx;
    logic [ADDRWIDTH-1:0]     addr_sel;
    logic [DATAWIDTH_BUS-1:0] data_sel;
    logic [NUM_REGS-1:0]      wr_dec;

    // Last cycle's acknowledge blocks a stale Req; a continuing lock owner bypasses this via owner_hold.
    assign eligible = SC_RegWRARB_Req_In & ~ack_q;

    sc_rr_picker #(
        .N  (NUM_REQ),
        .IW (PTR_W)
    ) u_picker (
        .eligible_i  (eligible),
        .ptr_i       (ptr_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx),
        .any_valid_o (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        count_d  = count_q;
        grant    = 1'b0;
        gidx     = owner_q;
        ack_d    = '0;
        addr_sel = '0;
        data_sel = '0;
        wr_dec   = '0;

        owner_hold = (state_q == ST_LOCKED) && SC_RegWRARB_Req_In[owner_q]
                     && SC_RegWRARB_Lock_In[owner_q] && (count_q < CNT_W'(MAX_HOLD));

        // Lock continuation wins; otherwise (including forced release) re-arbitrate like IDLE.
        if (owner_hold) begin
            grant   = 1'b1;
            gidx    = owner_q;
            ack_d   = NUM_REQ'(1) << owner_q;
            count_d = count_q + CNT_W'(1);
        end else if (pick_any) begin
            grant = 1'b1;
            gidx  = pick_idx;
            ack_d = pick_oh;
            ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            if (SC_RegWRARB_Lock_In[pick_idx]) begin
                state_d = ST_LOCKED;
                owner_d = pick_idx;
                count_d = CNT_W'(1);
            end else begin
                state_d = ST_GRANT;
                count_d = '0;
            end
        end else begin
            state_d = ST_IDLE;
            count_d = '0;
        end

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gidx == PTR_W'(i)) begin
                addr_sel = SC_RegWRARB_Addr_In[i*ADDRWIDTH +: ADDRWIDTH];
                data_sel = SC_RegWRARB_Data_In[i*DATAWIDTH_BUS +: DATAWIDTH_BUS];
            end
        end

        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            wr_dec[r] = reg_select(8'(addr_sel), r, NUM_REGS);
        end

        write_d = grant ? wr_dec : '0;
        error_d = grant && !addr_in_range(8'(addr_sel), NUM_REGS);
        data_d  = grant ? data_sel : data_q;
        busy_d  = (state_d == ST_LOCKED);
    end

    always_ff @(posedge SC_RegWRARB_CLOCK_50 or negedge SC_RegWRARB_Reset_InLow) begin
        if (!SC_RegWRARB_Reset_InLow) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            count_q <= '0;
            ack_q   <= '0;
            write_q <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            count_q <= count_d;
            ack_q   <= ack_d;
            write_q <= write_d;
            data_q  <= data_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    assign SC_RegWRARB_Ack_Out     = ack_q;
    assign SC_RegWRARB_Write_Out   = write_q;
    assign SC_RegWRARB_DataBUS_Out = data_q;
    assign SC_RegWRARB_Error_Out   = error_q;
    assign SC_RegWRARB_Busy_Out    = busy_q;

endmodule

// File: tb/tb_sc_reg_write_arbiter.sv
// Scoreboard bench for sc_reg_write_arbiter: directed stimulus pushes expectations, a monitor pops and compares.
module tb_sc_reg_write_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned NREG = 6;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 3;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [NREG-1:0] wr;
        logic [DW-1:0]   data;
        logic            err;
        logic            busy;
        string           tag;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     lock;
    logic [NREQ*AW-1:0]  addr_bus;
    logic [NREQ*DW-1:0]  data_bus;
    logic [NREQ-1:0]     ack;
    logic [NREG-1:0]     wr;
    logic [DW-1:0]       dbus;
    logic                err;
    logic                busy;

    logic [AW-1:0]       adr [NREQ];
    logic [DW-1:0]       dat [NREQ];
    logic [DW-1:0]       last_data;
    exp_t                q[$];
    int                  vectors = 0;
    int                  miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_bus[i*AW +: AW] = adr[i];
            data_bus[i*DW +: DW] = dat[i];
        end
    end

    sc_reg_write_arbiter #(
        .DATAWIDTH_BUS (DW),
        .NUM_REQ       (NREQ),
        .NUM_REGS      (NREG),
        .ADDRWIDTH     (AW),
        .MAX_HOLD      (4)
    ) dut (
        .SC_RegWRARB_CLOCK_50    (clk),
        .SC_RegWRARB_Reset_InLow (rst_n),
        .SC_RegWRARB_Req_In      (req),
        .SC_RegWRARB_Lock_In     (lock),
        .SC_RegWRARB_Addr_In     (addr_bus),
        .SC_RegWRARB_Data_In     (data_bus),
        .SC_RegWRARB_Ack_Out     (ack),
        .SC_RegWRARB_Write_Out   (wr),
        .SC_RegWRARB_DataBUS_Out (dbus),
        .SC_RegWRARB_Error_Out   (err),
        .SC_RegWRARB_Busy_Out    (busy)
    );

    // Drive one cycle of requests and queue what the following posedge must produce (w<0: no grant).
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input int w,
                        input logic b, input string tag);
        exp_t e;
        @(negedge clk);
        req  = r;
        lock = l;
        e.ack  = '0;
        e.wr   = '0;
        e.err  = 1'b0;
        e.busy = b;
        e.tag  = tag;
        if (w >= 0) begin
            e.ack     = NREQ'(1) << w;
            last_data = dat[w];
            if (adr[w] < 3'd6) e.wr = NREG'(1) << adr[w];
            else               e.err = 1'b1;
        end
        e.data = last_data;
        q.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        vectors++;
        if (ack !== '0 || wr !== '0 || dbus !== '0 || err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: ack=%b wr=%b data=%h err=%b busy=%b, required all zero",
                     tag, ack, wr, dbus, err, busy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        #1 check_reset("sync_reset");
        last_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per cycle, compared just after the active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (ack !== e.ack || wr !== e.wr || dbus !== e.data || err !== e.err || busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL %s: ack=%b wr=%b data=%h err=%b busy=%b, required ack=%b wr=%b data=%h err=%b busy=%b",
                             e.tag, ack, wr, dbus, err, busy, e.ack, e.wr, e.data, e.err, e.busy);
                end
            end else if (ack !== '0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: ack=%b, required 0000", ack);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        last_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            adr[i] = '0;
            dat[i] = '0;
        end
        @(posedge clk);
        #1 check_reset("power_on_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, then exclusion of its stale Req.
        adr[0] = 3'd5; dat[0] = 32'hDEAD_BEEF;
        step(4'b0001, 4'b0000,  0, 1'b0, "single_grant");
        step(4'b0001, 4'b0000, -1, 1'b0, "stale_req_excluded");
        step(4'b0000, 4'b0000, -1, 1'b0, "idle_after_single");

        // Round-robin rotation with all requesters active.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            adr[i] = AW'(i + 1);
            dat[i] = 32'h1000_0000 * (i + 1) + 32'(i);
        end
        step(4'b1111, 4'b0000,  0, 1'b0, "rr_0");
        step(4'b1111, 4'b0000,  1, 1'b0, "rr_1");
        step(4'b1111, 4'b0000,  2, 1'b0, "rr_2");
        step(4'b1111, 4'b0000,  3, 1'b0, "rr_3");
        step(4'b1111, 4'b0000,  0, 1'b0, "rr_wrap");
        step(4'b0000, 4'b0000, -1, 1'b0, "rr_idle");

        // Burst lock: MAX_HOLD grants, forced release, relock, voluntary lock drop.
        do_reset();
        adr[0] = 3'd0; dat[0] = 32'h1111_0000;
        adr[2] = 3'd2; dat[2] = 32'h2222_0002;
        step(4'b0101, 4'b0001,  0, 1'b1, "lock_e1");
        step(4'b0101, 4'b0001,  0, 1'b1, "lock_e2");
        step(4'b0101, 4'b0001,  0, 1'b1, "lock_e3");
        step(4'b0101, 4'b0001,  0, 1'b1, "lock_e4");
        step(4'b0101, 4'b0001,  2, 1'b0, "forced_release");
        step(4'b0101, 4'b0001,  0, 1'b1, "relock");
        step(4'b0101, 4'b0001,  0, 1'b1, "relock_e2");
        step(4'b0101, 4'b0000,  2, 1'b0, "lock_drop");
        step(4'b0000, 4'b0000, -1, 1'b0, "lock_idle");

        // Out-of-range addresses and Lock without Req.
        do_reset();
        adr[1] = 3'd7; dat[1] = 32'h7777_0001;
        adr[3] = 3'd6; dat[3] = 32'h6666_0003;
        step(4'b0010, 4'b0000,  1, 1'b0, "err_addr7");
        step(4'b0000, 4'b1111, -1, 1'b0, "lock_without_req");
        step(4'b1000, 4'b0000,  3, 1'b0, "err_addr6");
        step(4'b0000, 4'b0000, -1, 1'b0, "err_idle");

        // Asynchronous reset in the middle of a locked burst.
        do_reset();
        adr[0] = 3'd3; dat[0] = 32'h5555_AAAA;
        adr[3] = 3'd4; dat[3] = 32'h3333_4444;
        step(4'b0001, 4'b0001,  0, 1'b1, "pre_reset_lock_e1");
        step(4'b0001, 4'b0001,  0, 1'b1, "pre_reset_lock_e2");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        #1 check_reset("async_reset_mid_lock");
        last_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1000, 4'b0000,  3, 1'b0, "post_reset_grant");
        step(4'b0000, 4'b0000, -1, 1'b0, "post_reset_idle");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
